// File: rtl/vc_fifo_buffer_if.sv
// Bus between the link receiver / switch control and the multi-VC input buffer.
interface vc_fifo_buffer_if #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int NUM_VC = 2
);
    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;

    logic                    push;
    logic [VCW-1:0]          push_vc;
    logic [WIDTH-1:0]        tail;
    logic [NUM_VC-1:0]       pull;
    logic [NUM_VC*WIDTH-1:0] head;
    logic [NUM_VC*CW-1:0]    counter;
    logic [NUM_VC-1:0]       full;
    logic [NUM_VC-1:0]       empty;
    logic [NUM_VC-1:0]       credit;
    logic                    overflow;
    logic                    underflow;

    modport master (
        output push, push_vc, tail, pull,
        input  head, counter, full, empty, credit, overflow, underflow
    );

    modport slave (
        input  push, push_vc, tail, pull,
        output head, counter, full, empty, credit, overflow, underflow
    );
endinterface

// File: rtl/vc_fifo_buffer.sv
// Multi-virtual-channel input buffer: NUM_VC circular FIFOs sharing one write
// port, each with its own pull, occupancy counter, full/empty and credit pulse.
module vc_fifo_buffer #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int NUM_VC = 2
) (
    input logic             clock,
    input logic             reset,
    vc_fifo_buffer_if.slave bus
);
    localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int PW  = $clog2(DEPTH);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [WIDTH-1:0]  mem_q [NUM_VC][DEPTH];
    logic [WIDTH-1:0]  mem_d [NUM_VC][DEPTH];
    ptr_t              rd_q  [NUM_VC];
    ptr_t              rd_d  [NUM_VC];
    ptr_t              wr_q  [NUM_VC];
    ptr_t              wr_d  [NUM_VC];
    cnt_t              cnt_q [NUM_VC];
    cnt_t              cnt_d [NUM_VC];
    logic [NUM_VC-1:0] full_q, full_d;
    logic [NUM_VC-1:0] empty_q, empty_d;
    logic [NUM_VC-1:0] credit_q, credit_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    logic [NUM_VC-1:0] pull_acc;
    logic [NUM_VC-1:0] push_acc;
    logic [VCW-1:0]    vc_sel;
    logic              vc_ok;

    // Circular pointer increment; DEPTH need not be a power of two.
    function automatic ptr_t ptr_inc(input ptr_t p);
        ptr_t r;
        if (p == ptr_t'(DEPTH - 1)) begin
            r = {PW{1'b0}};
        end else begin
            r = p + ptr_t'(1);
        end
        return r;
    endfunction

    // Acceptance: pulls need a non-empty VC; a push needs a valid VC and either
    // room or a simultaneous accepted pull on the same VC.
    always_comb begin
        vc_sel   = (NUM_VC == 1) ? {VCW{1'b0}} : bus.push_vc;
        vc_ok    = (NUM_VC == 1) || (int'(bus.push_vc) < NUM_VC);
        pull_acc = {NUM_VC{1'b0}};
        push_acc = {NUM_VC{1'b0}};
        for (int v = 0; v < NUM_VC; v++) begin
            pull_acc[v] = bus.pull[v] & ~empty_q[v];
            push_acc[v] = bus.push & vc_ok & (int'(vc_sel) == v) &
                          (~full_q[v] | pull_acc[v]);
        end
    end

    // Next-state for pointers, storage, occupancy, flags and credit pulses.
    always_comb begin
        mem_d = mem_q;
        for (int v = 0; v < NUM_VC; v++) begin
            rd_d[v]  = pull_acc[v] ? ptr_inc(rd_q[v]) : rd_q[v];
            wr_d[v]  = push_acc[v] ? ptr_inc(wr_q[v]) : wr_q[v];
            if (push_acc[v]) begin
                mem_d[v][wr_q[v]] = bus.tail;
            end else begin
                mem_d[v][wr_q[v]] = mem_q[v][wr_q[v]];
            end
            cnt_d[v]   = cnt_q[v] + cnt_t'(push_acc[v]) - cnt_t'(pull_acc[v]);
            full_d[v]  = (cnt_d[v] == cnt_t'(DEPTH));
            empty_d[v] = (cnt_d[v] == {CW{1'b0}});
        end
        credit_d    = pull_acc;
        overflow_d  = overflow_q | (bus.push & ~(|push_acc));
        underflow_d = underflow_q | (|(bus.pull & empty_q));
    end

    // Control state; synchronous reset discards all queued flits.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_q[v]  <= {PW{1'b0}};
                wr_q[v]  <= {PW{1'b0}};
                cnt_q[v] <= {CW{1'b0}};
            end
            full_q      <= {NUM_VC{1'b0}};
            empty_q     <= {NUM_VC{1'b1}};
            credit_q    <= {NUM_VC{1'b0}};
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            credit_q    <= credit_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Flit storage is deliberately not reset.
    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    // Head of each VC (zero while empty) and packed occupancy fields.
    always_comb begin
        bus.head    = {(NUM_VC*WIDTH){1'b0}};
        bus.counter = {(NUM_VC*CW){1'b0}};
        for (int v = 0; v < NUM_VC; v++) begin
            if (empty_q[v]) begin
                bus.head[v*WIDTH +: WIDTH] = {WIDTH{1'b0}};
            end else begin
                bus.head[v*WIDTH +: WIDTH] = mem_q[v][rd_q[v]];
            end
            bus.counter[v*CW +: CW] = cnt_q[v];
        end
    end

    assign bus.full      = full_q;
    assign bus.empty     = empty_q;
    assign bus.credit    = credit_q;
    assign bus.overflow  = overflow_q;
    assign bus.underflow = underflow_q;
endmodule
